// File: rtl/twiddle_pkg.sv
// Shared constants, fixed-point word type and elaboration-time helpers for the
// quarter-wave twiddle generator.
package twiddle_pkg;

  localparam int TW_N_MAX = 1024;
  localparam int TW_I     = 2;
  localparam int TW_F     = 14;
  localparam int TW_L     = $clog2(TW_N_MAX);
  localparam int TW_Q     = TW_N_MAX / 4;
  localparam int TW_DEPTH = TW_Q + 1;
  localparam int TW_AW    = TW_L - 1;
  localparam int TW_LNW   = $clog2(TW_L + 1);
  localparam int ONE      = 2 ** TW_F;

  typedef logic signed [TW_I+TW_F-1:0] tw_word_t;

  // round(cos(2*pi*a/n_max) * 2^f); Taylor series is exact to double precision on [0, pi/2]
  function automatic int tw_cos_fix(input int a, input int n_max, input int f);
    real x, term, acc;
    x    = 2.0 * 3.14159265358979323846 * real'(a) / real'(n_max);
    term = 1.0;
    acc  = 1.0;
    for (int n = 1; n < 16; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      acc  = acc + term;
    end
    return $rtoi(acc * real'(2 ** f) + 0.5);
  endfunction

  function automatic int tw_clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/twiddle_gen_qw_qrom.sv
// Quarter-wave cosine table with two registered read ports (stage S2).
// Contents are computed at elaboration.
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int    N_MAX     = TW_N_MAX,
  parameter int    W         = TW_I + TW_F,
  parameter int    F         = TW_F,
  parameter string INIT_FILE = "twiddle_qw.hex",
  localparam int   DEPTH     = N_MAX / 4 + 1,
  localparam int   AW        = $clog2(N_MAX) - 1
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic [W-1:0]  rd_a_o,
  output logic [W-1:0]  rd_b_o
);

  function automatic logic [DEPTH*W-1:0] build_img();
    logic [DEPTH*W-1:0] img;
    img = '0;
    for (int a = 0; a < DEPTH; a++) img[a*W +: W] = W'(tw_cos_fix(a, N_MAX, F));
    return img;
  endfunction

  localparam logic [DEPTH*W-1:0] ROM_IMG = build_img();

  logic [W-1:0] rom [DEPTH];
  logic [W-1:0] rd_a_q, rd_b_q;

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    assign rom[a] = ROM_IMG[a*W +: W];
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      rd_a_q <= rom[addr_a_i];
      rd_b_q <= rom[addr_b_i];
    end
  end

  assign rd_a_o = rd_a_q;
  assign rd_b_o = rd_b_q;

endmodule

// File: rtl/twiddle_gen_qw.sv
// Pipelined twiddle generator W = exp(-j*2*pi*k/N) from a quarter-wave table, latency 3.
// Define TWIDDLE_INVERSE_EN to honour i_inverse (conjugate output for the IFFT).
module twiddle_gen_qw
  import twiddle_pkg::*;
#(
  parameter int    N_MAX     = TW_N_MAX,
  parameter int    I         = TW_I,
  parameter int    F         = TW_F,
  parameter string INIT_FILE = "twiddle_qw.hex",
  localparam int   W         = I + F,
  localparam int   L         = $clog2(N_MAX),
  localparam int   KW        = L - 1,
  localparam int   LNW       = $clog2(L + 1)
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic [KW-1:0]       i_k,
  input  logic [LNW-1:0]      i_log2n,
  input  logic                i_inverse,
  output logic                o_valid,
  output logic signed [W-1:0] o_re,
  output logic signed [W-1:0] o_im
);

  localparam logic [KW-1:0]  QV   = KW'(N_MAX / 4);
  localparam logic [LNW-1:0] LN_L = LNW'(L);

  function automatic logic signed [W-1:0] neg_sel(input logic [W-1:0] x, input logic neg);
    logic signed [W-1:0] xs;
    xs = signed'(x);
    return neg ? ('0 - xs) : xs;
  endfunction

  logic [LNW-1:0] ln_c, sh_c;
  logic [KW-1:0]  m_c, mp_c;
  logic [KW-1:0]  addr_re_d, addr_im_d;
  logic           neg_re_d, neg_im_d;

  always_comb begin
    ln_c = LNW'(tw_clamp(int'(i_log2n), 2, L));
    sh_c = LN_L - ln_c;
    // k bits at and above log2n-1 fall off the top of the KW-bit shift
    m_c  = i_k << sh_c;
    mp_c = m_c - QV;
    if (m_c <= QV) begin
      addr_re_d = m_c;
      addr_im_d = QV - m_c;
      neg_re_d  = 1'b0;
    end else begin
      addr_re_d = QV - mp_c;
      addr_im_d = mp_c;
      neg_re_d  = 1'b1;
    end
  end

  assign neg_im_d = 1'b1;

  logic [KW-1:0]       addr_re_q, addr_im_q;
  logic                neg_re_q, neg_im_q, neg_re_s2_q, neg_im_s2_q, neg_im_s3;
  logic                vld_s1_q, vld_s2_q, o_valid_q;
  logic [W-1:0]        rd_re, rd_im;
  logic signed [W-1:0] o_re_q, o_im_q;

`ifdef TWIDDLE_INVERSE_EN
  logic conj_q, conj_s2_q;
  always_ff @(posedge clk) begin
    if (i_en) begin
      conj_q    <= i_inverse;
      conj_s2_q <= conj_q;
    end
  end
  assign neg_im_s3 = neg_im_s2_q ^ conj_s2_q;
`else
  logic unused_inverse;
  assign unused_inverse = i_inverse;
  assign neg_im_s3      = neg_im_s2_q;
`endif

  // S1: addresses and sign flags
  always_ff @(posedge clk) begin
    if (i_en) begin
      addr_re_q   <= addr_re_d;
      addr_im_q   <= addr_im_d;
      neg_re_q    <= neg_re_d;
      neg_im_q    <= neg_im_d;
      neg_re_s2_q <= neg_re_q;
      neg_im_s2_q <= neg_im_q;
    end
  end

  // S2: registered table reads
  twiddle_qrom #(
    .N_MAX    (N_MAX),
    .W        (W),
    .F        (F),
    .INIT_FILE(INIT_FILE)
  ) u_qrom (
    .clk     (clk),
    .en_i    (i_en),
    .addr_a_i(addr_re_q),
    .addr_b_i(addr_im_q),
    .rd_a_o  (rd_re),
    .rd_b_o  (rd_im)
  );

  // S3: sign application, output register; valid chain and outputs cleared on reset
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      vld_s1_q  <= 1'b0;
      vld_s2_q  <= 1'b0;
      o_valid_q <= 1'b0;
      o_re_q    <= '0;
      o_im_q    <= '0;
    end else if (i_en) begin
      vld_s1_q  <= i_valid;
      vld_s2_q  <= vld_s1_q;
      o_valid_q <= vld_s2_q;
      o_re_q    <= neg_sel(rd_re, neg_re_s2_q);
      o_im_q    <= neg_sel(rd_im, neg_im_s3);
    end
  end

  assign o_valid = o_valid_q;
  assign o_re    = o_re_q;
  assign o_im    = o_im_q;

endmodule

// File: tb/tb_twiddle_gen_qw.sv
// Scoreboard bench for twiddle_gen_qw at N_MAX=16, I=2, F=14 (1.0 = 16384).
module tb_twiddle_gen_qw;

  localparam int N_MAX = 16;
  localparam int W     = 16;
  localparam int KW    = 3;
  localparam int LNW   = 3;
`ifdef TWIDDLE_INVERSE_EN
  localparam int INV_IM = 11585;
`else
  localparam int INV_IM = -11585;
`endif

  logic                clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic                i_en = 1'b1;
  logic                i_valid = 1'b0;
  logic                i_inverse = 1'b0;
  logic [KW-1:0]       i_k = '0;
  logic [LNW-1:0]      i_log2n = '0;
  logic                o_valid;
  logic signed [W-1:0] o_re, o_im;

  always #5 clk = ~clk;

  twiddle_gen_qw #(
    .N_MAX    (N_MAX),
    .I        (2),
    .F        (14),
    .INIT_FILE("twiddle_qw.hex")
  ) dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_en     (i_en),
    .i_valid  (i_valid),
    .i_k      (i_k),
    .i_log2n  (i_log2n),
    .i_inverse(i_inverse),
    .o_valid  (o_valid),
    .o_re     (o_re),
    .o_im     (o_im)
  );

  typedef struct {
    int re;
    int im;
    int tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic new_edge = 1'b0;
  logic hold_vld = 1'b0;
  int   hold_re = 0, hold_im = 0, hold_tag = -1;

  task automatic check(input string nm, input int tag, input int act_v, input int exp_v,
                       input int act_re, input int exp_re, input int act_im, input int exp_im);
    n_checks++;
    if (act_v == exp_v && act_re == exp_re && act_im == exp_im) n_pass++;
    else $display("FAIL %s[%0d]: got v=%0d re=%0d im=%0d, expected v=%0d re=%0d im=%0d",
                  nm, tag, act_v, act_re, act_im, exp_v, exp_re, exp_im);
  endtask

  // An edge produces new output only when enabled or resetting
  always @(posedge clk) new_edge <= i_en || !i_rst_n;

  always @(negedge clk) begin
    if (new_edge) begin
      if (o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected", -1, 1, 0, int'(o_re), 0, int'(o_im), 0);
          hold_vld <= 1'b0;
        end else begin
          check("out", sb[0].tag, 1, 1, int'(o_re), sb[0].re, int'(o_im), sb[0].im);
          hold_vld <= 1'b1;
          hold_re  <= sb[0].re;
          hold_im  <= sb[0].im;
          hold_tag <= sb[0].tag;
          void'(sb.pop_front());
        end
      end else begin
        hold_vld <= 1'b0;
      end
    end else begin
      check("stall", hold_tag, int'(o_valid), int'(hold_vld),
            hold_vld ? int'(o_re) : 0, hold_vld ? hold_re : 0,
            hold_vld ? int'(o_im) : 0, hold_vld ? hold_im : 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input int ln, input int inv, input int re, input int im,
                       input int tag, input int stall);
    exp_t e;
    i_k       = KW'(k);
    i_log2n   = LNW'(ln);
    i_inverse = inv[0];
    i_valid   = 1'b1;
    e.re = re; e.im = im; e.tag = tag;
    sb.push_back(e);
    if (stall > 0) begin
      i_en = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
      i_en = 1'b1;
    end
    @(posedge clk);
    #1;
    i_valid   = 1'b0;
    i_inverse = 1'b0;
  endtask

  // Forward twiddles for N=16, k=0..7
  int ref_re [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  int ref_im [8] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset", -1, int'(o_valid), 0, int'(o_re), 0, int'(o_im), 0);
    i_rst_n = 1'b1;
    idle(1);

    issue(0, 4, 0, 16384, 0, 0, 0);
    issue(4, 4, 0, 0, -16384, 1, 0);
    issue(2, 4, 0, 11585, -11585, 2, 0);
    issue(1, 3, 0, 11585, -11585, 3, 0);
    issue(6, 4, 0, -11585, -11585, 4, 0);
    issue(6, 4, 1, -11585, INV_IM, 5, 0);
    issue(5, 3, 0, 11585, -11585, 6, 0);
    issue(1, 2, 0, 0, -16384, 7, 0);
    issue(1, 1, 0, 0, -16384, 8, 0);
    issue(0, 0, 0, 16384, 0, 9, 0);
    issue(3, 7, 0, 6270, -15137, 10, 0);
    issue(1, 4, 0, 15137, -6270, 11, 0);
    idle(6);

    for (int k = 0; k < 8; k++) issue(k, 4, 0, ref_re[k], ref_im[k], 20 + k, (k == 4) ? 2 : 0);
    idle(6);

    // Three requests in flight, the third launched with reset asserted
    i_log2n = 3'd4;
    i_k = 3'd1; i_valid = 1'b1;
    idle(1);
    i_k = 3'd3;
    idle(1);
    i_k = 3'd5; i_rst_n = 1'b0;
    idle(1);
    i_rst_n = 1'b1; i_valid = 1'b0;
    check("flush", -1, int'(o_valid), 0, int'(o_re), 0, int'(o_im), 0);
    idle(4);
    issue(7, 4, 0, -15137, -6270, 100, 0);

    for (int c = 0; c < 20 && sb.size() != 0; c++) idle(1);
    idle(5);
    check("drain", -1, sb.size(), 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
